// File: rtl/cpu_defs.sv
// Shared definitions for the memory-stage access controller: FSM encoding,
// timeout counter width and the default bus timeout.
package cpu_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } me_state_t;

  localparam int          CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter for the data-memory bus; expired flags the last
// cycle an outstanding request may still be acknowledged.
module bus_timeout_cnt
  import cpu_defs::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset_0,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// ME-stage access controller: launches one req/ack bus transaction per
// load/store, stalls the pipeline until it completes, and returns load data.
module mem_access_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [31:0] ans_me,
  input  logic [31:0] wd_me,
  input  logic        rmem_me,
  input  logic        wmem_me,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] mo_me,
  output logic        stall,
  output logic        bus_err
);

  me_state_t state;
  logic      mem_op;
  logic      misaligned;
  logic      launch;
  logic      cnt_en;
  logic      expired;

  assign mem_op     = rmem_me | wmem_me;
  assign misaligned = (ans_me[1:0] != 2'b00);
  assign launch     = (state == S_IDLE) && mem_op && !misaligned;
  assign cnt_en     = (state == S_WAIT) && !mem_ack;

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset_0 (reset_0),
    .clear   (launch),
    .enable  (cnt_en),
    .expired (expired)
  );

  // Stall is raised combinationally in IDLE so the very cycle that presents
  // the memory op is already held; DONE releases the pipeline.
  always_comb begin
    // NOTE: default first, so no path through the case leaves stall unassigned
    // and a latch is never inferred.
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = mem_op;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mo_me     <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              mo_me   <= '0;
              bus_err <= 1'b1;
              state   <= S_DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= wmem_me & ~rmem_me;
              mem_addr  <= ans_me[31:2];
              mem_wdata <= wd_me;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // An ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            if (!mem_we) mo_me <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_DONE;
          end else if (expired) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mo_me   <= '0;
            bus_err <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the 5-stage MIPS pipeline. It sits between the EX->ME pipeline register and the ME->WB pipeline register, and drives a multi-cycle data-memory bus with a req/ack handshake. It produces the ME-stage load data (`mo_me`) and the pipeline-wide `stall` that gates the pipeline-register `enable` inputs. Each load or store holds the pipeline until the bus acknowledges, times out, or the access is rejected as misaligned.

## Interface
- `TIMEOUT`, default 16: number of WAIT cycles without ack before the access is aborted; legal range 2..255.
- `clock` in 1: single clock, all state on rising edge.
- `reset_0` in 1: asynchronous, active-low reset.
- `ans_me` in 32: ALU result from EX->ME, used as the byte address.
- `wd_me` in 32: store data.
- `rmem_me` in 1: load in ME.
- `wmem_me` in 1: store in ME.
- `mem_req` out 1: bus request (registered).
- `mem_we` out 1: bus write strobe (registered, valid while `mem_req`).
- `mem_addr` out 30: word address = `ans_me[31:2]`, registered at request launch.
- `mem_wdata` out 32: registered store data.
- `mem_rdata` in 32: bus read data, valid in the ack cycle.
- `mem_ack` in 1: bus acknowledge, one-cycle pulse.
- `mo_me` out 32: load data to ME->WB.
- `stall` out 1: when 1, every pipeline register holds; the pipeline drives `enable = ~stall`.
- `bus_err` out 1: sticky error flag for a timeout or a misaligned access.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset forces IDLE.
- A memory op is `rmem_me | wmem_me`. If both are 1, it is treated as a load.
- **IDLE, no memory op:** `stall`=0 and no bus activity.
- **IDLE, memory op with `ans_me[1:0]`==0:**
  - `stall`=1 combinationally.
  - At the next edge, go to WAIT; set `mem_req`=1, `mem_we`=`wmem_me & ~rmem_me`; latch `mem_addr` and `mem_wdata`; clear the timeout counter.
- **IDLE, memory op with `ans_me[1:0]`!=0 (misaligned):**
  - `stall`=1.
  - At the next edge, go to DONE with `mo_me`=0 and `bus_err` set; no bus request is issued.
- **WAIT:** `stall`=1 and `mem_req` is held high with stable addr/data/we.
  - On `mem_ack`=1: at the edge, capture `mo_me`=`mem_rdata` (loads only; stores leave `mo_me` unchanged), clear `mem_req`, go to DONE.
  - On no ack: the counter increments. When the counter equals `TIMEOUT`-1 without ack, at the edge clear `mem_req`, set `mo_me`=0, set `bus_err`, go to DONE.
  - `mem_ack` in the same cycle as the timeout: the ack wins and no error is raised.
- **DONE:** `stall`=0, so the ME->WB register samples `mo_me` at this edge. Next state is IDLE unconditionally.
  - A new memory op that arrives in ME after this edge is detected in IDLE.
- `mem_ack` in IDLE or DONE is ignored.
- `bus_err` clears only on reset.
- `mo_me` is held between accesses.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mo_me`=0, `bus_err`=0, `stall`=0 (IDLE with no op), counter=0.
- Aligned access with ack in the first WAIT cycle:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: WAIT, ack.
  - Cycle 2: DONE, `stall`=0.
  - This gives 2 stall cycles, and the load data reaches WB at the end of cycle 2.
- Ack arriving n cycles after `mem_req` rises gives a total stall of n+2 cycles.
- Timeout: `stall` lasts `TIMEOUT`+1 cycles.
- Misaligned access: exactly 1 stall cycle.
- Back-to-back memory ops: a minimum of one non-stalled cycle (DONE) between accesses; `mem_req` is low for at least 1 cycle between requests.
- Reset mid-WAIT: `mem_req` drops asynchronously. The bus must tolerate an abandoned request, and a late ack is ignored.
- `stall` is combinational from `rmem_me`/`wmem_me`/`ans_me[1:0]` in IDLE. All other outputs are registered.

## Structure
- Shared package (`cpu_defs`): FSM state encodings (2 bits: IDLE=0, WAIT=1, DONE=2) and the default `TIMEOUT` constant.
- The timeout counter is 8 bits, compared against `TIMEOUT`-1.
- There is one natural sub-module, `bus_timeout_cnt`: a counter with clear/enable inputs and an `expired` output. The FSM, capture registers and stall logic stay in `mem_access_ctrl`.

## Test plan
- **Load:** `ans_me`=0x0000_0010, `rmem_me`=1, ack 3 cycles after `mem_req` with `mem_rdata`=0xCAFE_F00D.
  - Expect `mem_addr`=0x4, `mem_we`=0, `stall` high for 5 cycles.
  - Expect `mo_me`=0xCAFE_F00D in DONE and `bus_err`=0.
- **Store:** `ans_me`=0x20, `wd_me`=0x1234_5678, `wmem_me`=1, ack same cycle as request.
  - Expect `mem_we`=1, `mem_wdata`=0x1234_5678, 2 stall cycles, `mo_me` unchanged.
- **Timeout:** `TIMEOUT`=4, load, never ack.
  - Expect `mem_req` high for 4 cycles, then `mo_me`=0, `bus_err`=1 sticky, and `stall` low in the following DONE.
- **Misaligned:** `ans_me`=0x13, `rmem_me`=1.
  - Expect no `mem_req`, 1 stall cycle, `bus_err`=1, `mo_me`=0.
- **Back-to-back loads:** two consecutive loads, each acked immediately.
  - Expect two separate request pulses separated by ≥1 low cycle, and correct data for each.
- **Reset in WAIT:** pull `reset_0` low.
  - Expect immediate `mem_req`=0, `stall`=0, IDLE.
  - After release, a stray `mem_ack` produces no state change.
